// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode constants and fetch entry type
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular FIFO of fetch entries with push/pop/clear
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clear,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  head_q, head_d;
  logic [AW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + 1'b1;
      end
      if (pop) head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS fetch: PC, next-PC prediction, fetch queue, redirect
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        miss,
  input  logic [31:0] rpc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int             CW   = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0]  FULL = CW'(QDEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pc_plus4, npc;
  logic [CW-1:0] count;
  logic          push, pop;
  fetch_entry_t  head, push_entry;

  // Static prediction: branches taken, direct jumps followed, jr left to recovery
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    npc      = pc_plus4;
    case (imem_rdata[31:26])
      OP_BEQ, OP_BNE: npc = pc_plus4 + {{14{imem_rdata[15]}}, imem_rdata[15:0], 2'b00};
      OP_J, OP_JAL:   npc = {pc_plus4[31:28], imem_rdata[25:0], 2'b00};
      default:        npc = pc_plus4;
    endcase
  end

  assign out_valid  = (count != '0) & ~miss;
  assign pop        = out_valid & out_ready;
  assign push       = ~miss & ((count < FULL) | pop);
  assign push_entry = '{pc: pc_q, instr: imem_rdata};

  always_comb begin
    pc_d = pc_q;
    if (miss)      pc_d = rpc;
    else if (push) pc_d = npc;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (miss),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign imem_addr = pc_q;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        miss = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  int          prog = 0;
  int          checks = 0;
  int          errors = 0;

  localparam logic [31:0] BEQ_BACK = 32'h1000_FFFE;
  localparam logic [31:0] J_40     = 32'h0800_0040;

  always #5 clk = ~clk;

  // Program 1 places a backward beq at 8; program 2 a j at 0x1000_0010
  always_comb begin
    imem_rdata = 32'h0;
    if (prog == 1 && imem_addr == 32'h8)          imem_rdata = BEQ_BACK;
    if (prog == 2 && imem_addr == 32'h1000_0010)  imem_rdata = J_40;
  end

  fetch_stage dut (
    .clk        (clk),
    .resetn     (resetn),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .miss       (miss),
    .rpc        (rpc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    step();
    resetn    = 1'b0;
    miss      = 1'b0;
    out_ready = rdy;
    step();
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    // reset state
    step();
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc",    out_pc,    32'h0);
    check("rst_addr",  imem_addr, 32'h0);

    // straight-line nops
    do_reset(1'b1);
    check("seq0_valid", {31'b0, out_valid}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("seq_valid", {31'b0, out_valid}, 32'h1);
      check("seq_pc",    out_pc,    32'(4 * (k - 1)));
      check("seq_addr",  imem_addr, 32'(4 * k));
    end

    // predicted-taken beq at 8 back to 4
    prog = 1;
    do_reset(1'b1);
    step(); step(); step();
    check("br_pc",    out_pc,    32'h8);
    check("br_instr", out_instr, BEQ_BACK);
    check("br_addr",  imem_addr, 32'h4);
    step();
    check("br_tgt_pc", out_pc,   32'h4);
    check("br_addr2",  imem_addr, 32'h8);

    // redirect into a j at 0x1000_0010
    prog = 2;
    do_reset(1'b1);
    step(); step();
    miss = 1'b1;
    rpc  = 32'h1000_0010;
    #1;
    check("j_miss_valid", {31'b0, out_valid}, 32'h0);
    step();
    miss = 1'b0;
    #1;
    check("j_addr",  imem_addr, 32'h1000_0010);
    check("j_valid", {31'b0, out_valid}, 32'h0);
    step();
    check("j_out_pc",    out_pc,    32'h1000_0010);
    check("j_out_instr", out_instr, J_40);
    check("j_tgt_addr",  imem_addr, 32'h1000_0100);
    step();
    check("j_tgt_pc", out_pc, 32'h1000_0100);

    // stall with full queue, then release
    prog = 0;
    do_reset(1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("stall_pc",    out_pc,    32'h0);
      check("stall_valid", {31'b0, out_valid}, 32'h1);
      if (k >= 2) check("stall_addr", imem_addr, 32'h8);
    end
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_pc",    out_pc, 32'(4 * k));
      check("drain_valid", {31'b0, out_valid}, 32'h1);
      step();
    end

    // redirect with full queue and ready high, then back-to-back misses
    do_reset(1'b0);
    step(); step(); step();
    out_ready = 1'b1;
    miss      = 1'b1;
    rpc       = 32'h40;
    #1;
    check("rd_n_valid", {31'b0, out_valid}, 32'h0);
    step();
    miss = 1'b0;
    #1;
    check("rd_n1_valid", {31'b0, out_valid}, 32'h0);
    check("rd_n1_addr",  imem_addr, 32'h40);
    step();
    check("rd_n2_valid", {31'b0, out_valid}, 32'h1);
    check("rd_n2_pc",    out_pc, 32'h40);
    step();
    check("rd_n3_pc", out_pc, 32'h44);
    miss = 1'b1;
    rpc  = 32'h80;
    step();
    rpc  = 32'hC0;
    step();
    miss = 1'b0;
    #1;
    check("b2b_addr",  imem_addr, 32'hC0);
    check("b2b_valid", {31'b0, out_valid}, 32'h0);
    step();
    check("b2b_pc", out_pc, 32'hC0);

    // asynchronous reset while full, between clock edges
    do_reset(1'b0);
    step(); step(); step();
    check("ar_pre_valid", {31'b0, out_valid}, 32'h1);
    check("ar_pre_addr",  imem_addr, 32'h8);
    #1;
    resetn = 1'b0;
    #1;
    check("ar_valid", {31'b0, out_valid}, 32'h0);
    check("ar_addr",  imem_addr, 32'h0);
    check("ar_pc",    out_pc,    32'h0);
    step();
    resetn    = 1'b1;
    out_ready = 1'b1;
    step();
    check("ar_re_pc0", out_pc, 32'h0);
    step();
    check("ar_re_pc1", out_pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
